fir_sym_mac: RTL and testbench
==============================

Name: fir_sym_mac

Overview:
- Parametrised successor of the 3-tap fixed-size FIR datapath.
- Time-multiplexed, optionally symmetric (linear-phase) FIR:
  - one multiplier;
  - runtime-loadable coefficients;
  - AXI-Stream-style sample handshake;
  - rounding and saturation of the output.
- Sits between the x_n sample source and the y_n consumer, in the same position as the existing FIR.

Parameters:
- NBR_OF_TAPS, 3: unique coefficients N (>=2).
- TAP_SIZE, 3: signed coefficient width.
- X_N_SIZE, 8: signed sample width.
- Y_N_SIZE, 11: signed output width.
- SYMMETRIC, 1: filter shape.
  - 1: filter length L = 2N-1, coefficient order c0..c(N-1)..c0.
  - 0: L = N.
- OUT_SHIFT, 0: arithmetic right shift applied to the accumulator before saturation.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- x_n  in  X_N_SIZE  signed input sample.
- s_axis_fir_tvalid  in  1  x_n is valid.
- s_axis_fir_tready  out  1  block can accept a sample.
- s_set_coeffs  in  1  shift coeff_in into the coefficient chain.
- coeff_in  in  TAP_SIZE  signed coefficient.
- flush  in  1  clear the delay line.
- y_n  out  Y_N_SIZE  signed filtered output, registered, held between results.
- m_axis_fir_tvalid  out  1  one-cycle pulse when y_n is updated.

Behaviour:
- Clock and reset: one clock clk; reset is synchronous and active-high.
- Reset result:
  - state=IDLE; delay line all zero; acc=0; y_n=0; m_axis_fir_tvalid=0.
  - taps[N-1]=1 and all other taps=0 (unity passthrough delayed by N-1 samples).
  - Reset has priority over every other input and aborts any in-progress computation; no valid pulse is produced.
- States: IDLE, COMPUTE, OUTPUT.
- s_axis_fir_tready = (state==IDLE) && !s_set_coeffs && !flush.
- IDLE priority order is flush > s_set_coeffs > sample:
  - flush: delay line cleared to zero; taps unchanged; stay in IDLE.
  - s_set_coeffs (and no flush): taps[0]<=coeff_in, taps[i]<=taps[i-1]; stay in IDLE. After N shifts, the first word written is in taps[N-1].
  - tvalid && tready: buffs[0]<=x_n, buffs[i]<=buffs[i-1] (L entries, buffs[0] newest); k<=0; acc<=0; go to COMPUTE.
- COMPUTE: one MAC per cycle, k = 0..N-1; N cycles regardless of SYMMETRIC.
  - SYMMETRIC=1:
    - term = taps[k]*(buffs[k]+buffs[L-1-k]) for k<N-1.
    - term = taps[N-1]*buffs[N-1] for k=N-1.
    - The pre-add is X_N_SIZE+1 bits, sign-extended.
  - SYMMETRIC=0: term = taps[k]*buffs[k].
  - When k==N-1, go to OUTPUT.
- OUTPUT, one cycle:
  - r = (acc + (OUT_SHIFT>0 ? 2^(OUT_SHIFT-1) : 0)) >>> OUT_SHIFT.
  - y_n <= r clamped to [-2^(Y_N_SIZE-1), 2^(Y_N_SIZE-1)-1].
  - m_axis_fir_tvalid <= 1 for exactly this one cycle.
  - Next state IDLE.
- Latency: sample accepted at edge E0; y_n and the valid pulse appear after edge E(N+1). Throughput is one sample per N+2 cycles.
- Arithmetic:
  - ACC_W = X_N_SIZE+1+TAP_SIZE+clog2(N); all arithmetic is signed; no overflow inside the accumulator.
- Inputs outside IDLE:
  - s_set_coeffs and flush are ignored during COMPUTE/OUTPUT; taps and the delay line stay stable through a computation.
  - A held s_set_coeffs shifts on every IDLE cycle.
  - x_n and tvalid outside IDLE are ignored (not accepted, tready low).
- Boundaries:
  - s_set_coeffs and tvalid together in IDLE: the coefficient shift wins and the sample is not accepted.
  - flush together with either: flush wins.
  - Out-of-range coefficients do not exist (full signed TAP_SIZE range allowed, including -2^(TAP_SIZE-1)).

Decomposition:
- Package fir_pkg:
  - state enum (IDLE/COMPUTE/OUTPUT);
  - clog2 function;
  - ACC_W derivation;
  - saturate/round function.
- Sub-module fir_mac_unit: pre-adder + multiplier + accumulator with clear/enable. Controller and delay line stay in fir_sym_mac.

Test Plan:
- Defaults (N=3, L=5), no coeff load: impulse 100 then four 0 samples -> y_n sequence 0,0,100,0,0; each valid pulse arrives 4 cycles after its acceptance edge.
- Load coeffs written 3,2,1 (taps=[1,2,3]) then impulse 10 + four 0 -> 10,20,30,20,10.
- All taps 3, x_n=127 held for five samples -> fifth output saturates to 1023; repeat with -128 -> -1024.
- SYMMETRIC=0, N=4, taps [1,-1,2,1], OUT_SHIFT=1: impulse 9 -> 5,-4,9,5 (round half up after >>>1).
- s_set_coeffs and tvalid asserted together in IDLE -> tready=0, no sample accepted, taps shift. flush after data -> next impulse output shows no history.
- reset asserted in the 2nd COMPUTE cycle -> no valid pulse; y_n=0, taps back to unity; the next impulse 50 gives 0,0,50.

Source files
------------

// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the time-multiplexed symmetric FIR (fir_sym_mac).
//   fir_state_t : controller states
//   clog2       : ceiling log2 for elaboration-time width math
//   acc_width   : accumulator width that cannot overflow for a given geometry
//   round_sat   : round-half-up, arithmetic shift and clamp of the accumulator
// -----------------------------------------------------------------------------
package fir_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCompute,
        StOutput
    } fir_state_t;

    // Wide carrier for output post-processing; comfortably larger than any
    // realistic accumulator so the rounding add can never wrap.
    typedef logic signed [63:0] wide_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Pre-add grows the sample by one bit; N products of that by a coefficient
    // need clog2(N) guard bits.
    function automatic int unsigned acc_width(input int unsigned x_w,
                                              input int unsigned tap_w,
                                              input int unsigned n);
        return x_w + 1 + tap_w + clog2(n);
    endfunction

    function automatic wide_t round_sat(input wide_t acc,
                                        input int unsigned shift,
                                        input int unsigned y_w);
        wide_t rounded;
        wide_t lim_hi;
        wide_t lim_lo;
        rounded = acc;
        if (shift > 0) begin
            rounded = acc + (wide_t'(1) <<< (shift - 1));
        end
        rounded = rounded >>> shift;
        lim_hi  = (wide_t'(1) <<< (y_w - 1)) - wide_t'(1);
        lim_lo  = -(wide_t'(1) <<< (y_w - 1));
        if (rounded > lim_hi) begin
            rounded = lim_hi;
        end else if (rounded < lim_lo) begin
            rounded = lim_lo;
        end
        return rounded;
    endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// -----------------------------------------------------------------------------
// fir_mac_unit
// Pre-adder, single multiplier and accumulator of the FIR datapath.
//   clk     : clock
//   reset   : synchronous active-high reset, clears the accumulator
//   clear   : synchronous accumulator clear (start of a new output)
//   enable  : add coeff*(a+b) into the accumulator this cycle
//   a, b    : signed samples to pre-add (b is zero for an unpaired tap)
//   coeff   : signed coefficient
//   acc     : signed accumulator value
// -----------------------------------------------------------------------------
module fir_mac_unit #(
    parameter int unsigned X_W   = 8,
    parameter int unsigned TAP_W = 3,
    parameter int unsigned ACC_W = 14
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    enable,
    input  logic signed [X_W-1:0]   a,
    input  logic signed [X_W-1:0]   b,
    input  logic signed [TAP_W-1:0] coeff,
    output logic signed [ACC_W-1:0] acc
);

    localparam int unsigned PROD_W = X_W + 1 + TAP_W;

    logic signed [X_W:0]        pre_sum;
    logic signed [PROD_W-1:0]   product;
    logic signed [ACC_W-1:0]    acc_q;

    always_comb begin
        // Sign-extend both operands by one bit so the pair sum cannot wrap.
        pre_sum = (X_W + 1)'(a) + (X_W + 1)'(b);
        product = PROD_W'(pre_sum) * PROD_W'(coeff);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else if (clear) begin
            acc_q <= '0;
        end else if (enable) begin
            acc_q <= acc_q + ACC_W'(product);
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/fir_sym_mac.sv
// -----------------------------------------------------------------------------
// fir_sym_mac
// Time-multiplexed, optionally symmetric FIR with one multiplier, runtime
// loadable coefficients, valid/ready sample input, rounding and saturation.
//   clk               : clock, all state updates on the rising edge
//   reset             : synchronous active-high reset
//   x_n               : signed input sample
//   s_axis_fir_tvalid : x_n is valid
//   s_axis_fir_tready : a sample can be accepted this cycle
//   s_set_coeffs      : shift coeff_in into the coefficient chain (IDLE only)
//   coeff_in          : signed coefficient word
//   flush             : clear the delay line (IDLE only)
//   y_n               : registered filtered output, held between results
//   m_axis_fir_tvalid : one-cycle pulse when y_n is updated
// -----------------------------------------------------------------------------
module fir_sym_mac
    import fir_pkg::*;
#(
    parameter int unsigned NBR_OF_TAPS = 3,
    parameter int unsigned TAP_SIZE    = 3,
    parameter int unsigned X_N_SIZE    = 8,
    parameter int unsigned Y_N_SIZE    = 11,
    parameter int unsigned SYMMETRIC   = 1,
    parameter int unsigned OUT_SHIFT   = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic signed [X_N_SIZE-1:0] x_n,
    input  logic                       s_axis_fir_tvalid,
    output logic                       s_axis_fir_tready,
    input  logic                       s_set_coeffs,
    input  logic signed [TAP_SIZE-1:0] coeff_in,
    input  logic                       flush,
    output logic signed [Y_N_SIZE-1:0] y_n,
    output logic                       m_axis_fir_tvalid
);

    localparam int unsigned N     = NBR_OF_TAPS;
    localparam int unsigned L     = (SYMMETRIC != 0) ? (2 * N - 1) : N;
    localparam int unsigned ACC_W = acc_width(X_N_SIZE, TAP_SIZE, N);
    localparam int unsigned K_W   = (clog2(N) > 0) ? clog2(N) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(N - 1);

    fir_state_t state_q, state_d;

    logic [K_W-1:0]              k_q;
    logic signed [TAP_SIZE-1:0]  taps_q  [N];
    logic signed [X_N_SIZE-1:0]  buffs_q [L];

    logic                        accept;
    logic                        mac_clear;
    logic                        mac_en;
    logic                        out_load;
    logic signed [X_N_SIZE-1:0]  a_sel;
    logic signed [X_N_SIZE-1:0]  b_sel;
    logic signed [TAP_SIZE-1:0]  coeff_sel;
    logic signed [ACC_W-1:0]     acc;

    // Coefficient loads and flushes take the cycle, so no sample is taken then.
    assign s_axis_fir_tready = (state_q == StIdle) && !s_set_coeffs && !flush;
    assign accept            = s_axis_fir_tready && s_axis_fir_tvalid;

    // ---------------------------------------------------------------------
    // Controller
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mac_clear = 1'b0;
        mac_en    = 1'b0;
        out_load  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    mac_clear = 1'b1;
                    state_d   = StCompute;
                end
            end
            StCompute: begin
                mac_en = 1'b1;
                if (k_q == K_LAST) begin
                    state_d = StOutput;
                end
            end
            StOutput: begin
                out_load = 1'b1;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            k_q <= '0;
        end else if (mac_clear) begin
            k_q <= '0;
        end else if (mac_en) begin
            k_q <= k_q + K_W'(1);
        end
    end

    // ---------------------------------------------------------------------
    // Coefficient chain: reset to unity on the last tap (pure delay)
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < N; i++) begin
                taps_q[i] <= (i == N - 1) ? TAP_SIZE'(1) : '0;
            end
        end else if ((state_q == StIdle) && !flush && s_set_coeffs) begin
            taps_q[0] <= coeff_in;
            for (int unsigned i = 1; i < N; i++) begin
                taps_q[i] <= taps_q[i - 1];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Delay line, buffs_q[0] newest
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < L; i++) begin
                buffs_q[i] <= '0;
            end
        end else if ((state_q == StIdle) && flush) begin
            for (int unsigned i = 0; i < L; i++) begin
                buffs_q[i] <= '0;
            end
        end else if (accept) begin
            buffs_q[0] <= x_n;
            for (int unsigned i = 1; i < L; i++) begin
                buffs_q[i] <= buffs_q[i - 1];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Operand select for step k. In symmetric mode tap k pairs sample k with
    // its mirror L-1-k; the centre tap has no partner.
    // ---------------------------------------------------------------------
    always_comb begin
        a_sel     = '0;
        b_sel     = '0;
        coeff_sel = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (k_q == K_W'(i)) begin
                a_sel     = buffs_q[i];
                coeff_sel = taps_q[i];
                if ((SYMMETRIC != 0) && (i < N - 1)) begin
                    b_sel = buffs_q[L - 1 - i];
                end
            end
        end
    end

    fir_mac_unit #(
        .X_W   (X_N_SIZE),
        .TAP_W (TAP_SIZE),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk    (clk),
        .reset  (reset),
        .clear  (mac_clear),
        .enable (mac_en),
        .a      (a_sel),
        .b      (b_sel),
        .coeff  (coeff_sel),
        .acc    (acc)
    );

    // ---------------------------------------------------------------------
    // Output register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            y_n               <= '0;
            m_axis_fir_tvalid <= 1'b0;
        end else begin
            m_axis_fir_tvalid <= out_load;
            if (out_load) begin
                y_n <= Y_N_SIZE'(round_sat(wide_t'(acc), OUT_SHIFT, Y_N_SIZE));
            end
        end
    end

endmodule

// File: tb/tb_fir_sym_mac.sv
module tb_fir_sym_mac;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // DUT A: defaults (symmetric, N=3, L=5, no shift)
    logic              rst_a, vin_a, rdy_a, set_a, flush_a, vout_a;
    logic signed [7:0]  x_a;
    logic signed [2:0]  coef_a;
    logic signed [10:0] y_a;

    // DUT B: non-symmetric, N=4, OUT_SHIFT=1
    logic              rst_b, vin_b, rdy_b, set_b, flush_b, vout_b;
    logic signed [7:0]  x_b;
    logic signed [2:0]  coef_b;
    logic signed [10:0] y_b;

    fir_sym_mac #(
        .NBR_OF_TAPS (3), .TAP_SIZE (3), .X_N_SIZE (8), .Y_N_SIZE (11),
        .SYMMETRIC (1), .OUT_SHIFT (0)
    ) dut_a (
        .clk (clk), .reset (rst_a), .x_n (x_a), .s_axis_fir_tvalid (vin_a),
        .s_axis_fir_tready (rdy_a), .s_set_coeffs (set_a), .coeff_in (coef_a),
        .flush (flush_a), .y_n (y_a), .m_axis_fir_tvalid (vout_a)
    );

    fir_sym_mac #(
        .NBR_OF_TAPS (4), .TAP_SIZE (3), .X_N_SIZE (8), .Y_N_SIZE (11),
        .SYMMETRIC (0), .OUT_SHIFT (1)
    ) dut_b (
        .clk (clk), .reset (rst_b), .x_n (x_b), .s_axis_fir_tvalid (vin_b),
        .s_axis_fir_tready (rdy_b), .s_set_coeffs (set_b), .coeff_in (coef_b),
        .flush (flush_b), .y_n (y_b), .m_axis_fir_tvalid (vout_b)
    );

    // Scoreboards: expected y_n and the edge count at acceptance
    int qy_a[$], qt_a[$], qy_b[$], qt_b[$];

    typedef struct {
        bit sel;
        int x;
        int y;
    } vec_t;

    vec_t vecs[30];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Output monitors, sampled on the falling edge
    always @(negedge clk) begin
        if (vout_a) begin
            if (qy_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_valid: got pulse with y_n=%0d, expected none", y_a);
            end else begin
                check("a_y_n", int'(y_a), qy_a.pop_front());
                check("a_latency", cyc - qt_a.pop_front(), 4);
            end
        end
        if (vout_b) begin
            if (qy_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_valid: got pulse with y_n=%0d, expected none", y_b);
            end else begin
                check("b_y_n", int'(y_b), qy_b.pop_front());
                check("b_latency", cyc - qt_b.pop_front(), 5);
            end
        end
    end

    task automatic send(input bit sel, input int x, input int y, input bit push);
        int n;
        n = 0;
        @(negedge clk);
        if (!sel) begin x_a = 8'(x); vin_a = 1'b1; end
        else      begin x_b = 8'(x); vin_b = 1'b1; end
        #1;
        while (!(sel ? rdy_b : rdy_a) && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!(sel ? rdy_b : rdy_a)) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got tready=0 for %0d cycles, expected 1", n);
        end else if (push) begin
            if (!sel) begin qy_a.push_back(y); qt_a.push_back(cyc + 1); end
            else      begin qy_b.push_back(y); qt_b.push_back(cyc + 1); end
        end
        @(negedge clk);
        vin_a = 1'b0;
        vin_b = 1'b0;
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) send(vecs[i].sel, vecs[i].x, vecs[i].y, 1'b1);
    endtask

    task automatic shift_coeff(input bit sel, input int c);
        @(negedge clk);
        if (!sel) begin set_a = 1'b1; coef_a = 3'(c); end
        else      begin set_b = 1'b1; coef_b = 3'(c); end
    endtask

    task automatic release_ctl();
        @(negedge clk);
        set_a = 1'b0; flush_a = 1'b0; vin_a = 1'b0;
        set_b = 1'b0; flush_b = 1'b0; vin_b = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((qy_a.size() != 0 || qy_b.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (qy_a.size() != 0 || qy_b.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0",
                     qy_a.size() + qy_b.size());
            qy_a.delete(); qt_a.delete(); qy_b.delete(); qt_b.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no completion, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // A, unity taps: impulse passes after two samples of delay
        vecs[0]  = '{0, 100, 0};    vecs[1]  = '{0, 0, 0};      vecs[2]  = '{0, 0, 100};
        vecs[3]  = '{0, 0, 0};      vecs[4]  = '{0, 0, 0};
        // A, taps [1,2,3]: symmetric response 1,2,3,2,1
        vecs[5]  = '{0, 10, 10};    vecs[6]  = '{0, 0, 20};     vecs[7]  = '{0, 0, 30};
        vecs[8]  = '{0, 0, 20};     vecs[9]  = '{0, 0, 10};
        // A, taps all 3: positive ramp into saturation
        vecs[10] = '{0, 127, 381};  vecs[11] = '{0, 127, 762};  vecs[12] = '{0, 127, 1023};
        vecs[13] = '{0, 127, 1023}; vecs[14] = '{0, 127, 1023};
        // A, taps all 3: swing to negative saturation
        vecs[15] = '{0, -128, 1023}; vecs[16] = '{0, -128, 375}; vecs[17] = '{0, -128, -390};
        vecs[18] = '{0, -128, -1024}; vecs[19] = '{0, -128, -1024};
        // A, after flush: no history
        vecs[20] = '{0, 1, 3};
        // B, taps [1,-1,2,1], >>>1 with round half up
        vecs[21] = '{1, 9, 5};      vecs[22] = '{1, 0, -4};     vecs[23] = '{1, 0, 9};
        vecs[24] = '{1, 0, 5};      vecs[25] = '{1, -9, -4};    vecs[26] = '{1, -3, 3};
        // A, after reset abort: back to unity taps
        vecs[27] = '{0, 50, 0};     vecs[28] = '{0, 0, 0};      vecs[29] = '{0, 0, 50};

        rst_a = 1'b1; vin_a = 1'b0; set_a = 1'b0; flush_a = 1'b0; x_a = '0; coef_a = '0;
        rst_b = 1'b1; vin_b = 1'b0; set_b = 1'b0; flush_b = 1'b0; x_b = '0; coef_b = '0;
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        check("reset_y_a", int'(y_a), 0);
        check("reset_valid_a", int'(vout_a), 0);
        check("reset_tready_a", int'(rdy_a), 1);
        check("reset_y_b", int'(y_b), 0);
        check("reset_tready_b", int'(rdy_b), 1);

        run_vecs(0, 4);
        drain();

        // Load 3,2,1; first cycle also offers a sample that must be refused
        shift_coeff(0, 3);
        x_a = 8'sd55;
        vin_a = 1'b1;
        #1;
        check("set_blocks_tready", int'(rdy_a), 0);
        shift_coeff(0, 2);
        shift_coeff(0, 1);
        release_ctl();
        repeat (8) @(negedge clk);
        run_vecs(5, 9);
        drain();

        shift_coeff(0, 3);
        shift_coeff(0, 3);
        shift_coeff(0, 3);
        release_ctl();
        run_vecs(10, 19);
        drain();

        // Flush with set and tvalid: flush wins, taps kept, line cleared
        @(negedge clk);
        flush_a = 1'b1; set_a = 1'b1; coef_a = -3'sd4; vin_a = 1'b1; x_a = 8'sd77;
        #1;
        check("flush_blocks_tready", int'(rdy_a), 0);
        release_ctl();
        run_vecs(20, 20);
        drain();

        // set/flush during COMPUTE are ignored
        send(0, 2, 9, 1'b1);
        set_a = 1'b1; flush_a = 1'b1; coef_a = -3'sd4;
        #1;
        check("compute_tready", int'(rdy_a), 0);
        @(negedge clk);
        release_ctl();
        send(0, 0, 9, 1'b1);
        drain();
        check("y_n_held", int'(y_a), 9);

        // B: load 1,2,-1,1 -> taps [1,-1,2,1]
        shift_coeff(1, 1);
        shift_coeff(1, 2);
        shift_coeff(1, -1);
        shift_coeff(1, 1);
        release_ctl();
        run_vecs(21, 26);
        drain();

        // Reset in the second COMPUTE cycle of A aborts without a pulse
        send(0, 7, 0, 1'b0);
        @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_y_n", int'(y_a), 0);
        check("abort_tready", int'(rdy_a), 1);
        run_vecs(27, 29);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
